// File: rtl/rfile_sched.sv
// ---------------------------------------------------------------------------
// rfile_sched
//
// Arbitrates a single-ported register file between a two-source read client
// and a buffered write client. Writes are parked in a small FIFO and drained
// into the register file on cycles where no read is requested. Two things
// force a drain ahead of a pending read: a full buffer, or a run of
// STARVE_LIMIT consecutive reads granted while writes were waiting.
// Reads see the buffered and in-flight writes through forwarding. That lets
// a write sit in the buffer without breaking read-after-write ordering.
//
// Parameters
//   WBUF_DEPTH    number of write-buffer entries (1..4)
//   STARVE_LIMIT  maximum consecutive read grants while writes are waiting
//
// Ports
//   clk, reset                clock and asynchronous active-low reset
//   rd_req, rd_rs1_addr,      read request with two source indices
//     rd_rs2_addr
//   rd_ack                    read granted this cycle
//   rsp_valid, rsp_rs1,       registered read response, one cycle after
//     rsp_rs2                 rd_ack, held between grants
//   wr_req, wr_addr, wr_data  write request
//   wr_ready                  write accepted when wr_req && wr_ready
//   rf_rs1_addr, rf_rs2_addr, register-file read port (zero-extended index)
//     rf_read_rs1, rf_read_rs2
//   rf_rs1, rf_rs2            register-file read data (combinational)
//   rf_rd, rf_rd_data,        register-file write port (zero-extended index)
//     rf_rd_write
//
// Handshake: the write side follows valid/ready. A write transfers on every
// rising clk edge where wr_req and wr_ready are both high. wr_ready depends
// only on the buffer occupancy and reset, never on wr_req. A read needs no
// ready signal. rd_ack reports the grant in the same cycle. rd_req may stay
// high across cycles where rd_ack is low, and those cycles produce no
// response.
// ---------------------------------------------------------------------------
module rfile_sched #(
  parameter int WBUF_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [4:0]  rd_rs1_addr,
  input  logic [4:0]  rd_rs2_addr,
  output logic        rd_ack,
  output logic        rsp_valid,
  output logic [31:0] rsp_rs1,
  output logic [31:0] rsp_rs2,
  input  logic        wr_req,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic [31:0] rf_rs1_addr,
  output logic [31:0] rf_rs2_addr,
  output logic        rf_read_rs1,
  output logic        rf_read_rs2,
  output logic [31:0] rf_rd,
  output logic [31:0] rf_rd_data,
  output logic        rf_rd_write,
  input  logic [31:0] rf_rs1,
  input  logic [31:0] rf_rs2
);

  // Starvation counter is wide enough to hold STARVE_LIMIT itself.
  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    G_IDLE     = 2'd0,
    G_READ     = 2'd1,
    G_WRITE    = 2'd2,
    G_FORCE_WR = 2'd3
  } grant_e;

  // ---------------------------------------------------------------------
  // Write buffer storage. It is sized for the largest legal depth so that
  // a 2-bit pointer indexes it cleanly for every WBUF_DEPTH. Slots at and
  // above WBUF_DEPTH are never written or read.
  // ---------------------------------------------------------------------
  logic [4:0]    buf_addr [4];
  logic [31:0]   buf_data [4];
  logic [1:0]    rd_ptr;
  logic [1:0]    wr_ptr;
  logic [2:0]    count;
  logic [SW-1:0] starve_cnt;

  grant_e        grant;
  logic          buf_empty;
  logic          buf_full;
  logic          wr_accept;
  logic          push;
  logic          pop;
  logic [31:0]   res_rs1;
  logic [31:0]   res_rs2;

  // Advances a pointer by n slots, wrapping modulo WBUF_DEPTH. The argument
  // n is always below WBUF_DEPTH, so a single subtraction is enough.
  function automatic logic [1:0] ptr_add(input logic [1:0] p, input logic [2:0] n);
    logic [2:0] sum;
    sum = {1'b0, p} + n;
    if (sum >= 3'(WBUF_DEPTH)) begin
      sum = sum - 3'(WBUF_DEPTH);
    end
    return sum[1:0];
  endfunction

  assign buf_empty = (count == 3'd0);
  assign buf_full  = (count == 3'(WBUF_DEPTH));

  // wr_ready is gated by reset so it reads low while the block is held.
  assign wr_ready  = reset & ~buf_full;
  assign wr_accept = wr_req & wr_ready;
  // Writes to x0 complete the handshake but are dropped here.
  assign push      = wr_accept & (wr_addr != 5'd0);

  // ---------------------------------------------------------------------
  // Grant arbitration. A forced drain outranks a read. Otherwise reads win
  // and the buffer drains in the gaps.
  // ---------------------------------------------------------------------
  always_comb begin
    grant = G_IDLE;
    if (!reset) begin
      grant = G_IDLE;
    end else if (!buf_empty &&
                 (buf_full || (starve_cnt == SW'(STARVE_LIMIT)))) begin
      grant = G_FORCE_WR;
    end else if (rd_req) begin
      grant = G_READ;
    end else if (!buf_empty) begin
      grant = G_WRITE;
    end else begin
      grant = G_IDLE;
    end
  end

  assign pop = (grant == G_WRITE) || (grant == G_FORCE_WR);

  // Register-file port drive. Addresses follow their sources at all times.
  // Only the strobes depend on the grant, so reads and writes never
  // overlap.
  assign rd_ack      = (grant == G_READ);
  assign rf_read_rs1 = (grant == G_READ);
  assign rf_read_rs2 = (grant == G_READ);
  assign rf_rd_write = pop;
  assign rf_rs1_addr = {27'd0, rd_rs1_addr};
  assign rf_rs2_addr = {27'd0, rd_rs2_addr};
  assign rf_rd       = {27'd0, buf_addr[rd_ptr]};
  assign rf_rd_data  = buf_data[rd_ptr];

  // ---------------------------------------------------------------------
  // Read-data resolution. The buffer is walked from head (oldest) to tail
  // (youngest), so the last match wins. Next, a write being accepted this
  // same cycle overrides anything buffered. x0 always reads as zero.
  // ---------------------------------------------------------------------
  always_comb begin
    res_rs1 = rf_rs1;
    res_rs2 = rf_rs2;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < count) begin
        if (buf_addr[ptr_add(rd_ptr, 3'(k))] == rd_rs1_addr) begin
          res_rs1 = buf_data[ptr_add(rd_ptr, 3'(k))];
        end
        if (buf_addr[ptr_add(rd_ptr, 3'(k))] == rd_rs2_addr) begin
          res_rs2 = buf_data[ptr_add(rd_ptr, 3'(k))];
        end
      end
    end
    if (wr_accept && (wr_addr == rd_rs1_addr)) begin
      res_rs1 = wr_data;
    end
    if (wr_accept && (wr_addr == rd_rs2_addr)) begin
      res_rs2 = wr_data;
    end
    if (rd_rs1_addr == 5'd0) begin
      res_rs1 = 32'd0;
    end
    if (rd_rs2_addr == 5'd0) begin
      res_rs2 = 32'd0;
    end
  end

  // Buffer payload needs no reset. The count and pointers alone decide
  // which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= wr_addr;
      buf_data[wr_ptr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Control state and response registers.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= 2'd0;
      wr_ptr     <= 2'd0;
      count      <= 3'd0;
      starve_cnt <= '0;
      rsp_valid  <= 1'b0;
      rsp_rs1    <= 32'd0;
      rsp_rs2    <= 32'd0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_add(wr_ptr, 3'd1);
      end
      if (pop) begin
        rd_ptr <= ptr_add(rd_ptr, 3'd1);
      end
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      // Only reads that overtake waiting writes count toward starvation.
      if (buf_empty || pop) begin
        starve_cnt <= '0;
      end else if ((grant == G_READ) && (starve_cnt != SW'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      rsp_valid <= (grant == G_READ);
      if (grant == G_READ) begin
        rsp_rs1 <= res_rs1;
        rsp_rs2 <= res_rs2;
      end
    end
  end

endmodule

// File: tb/tb_rfile_sched.sv
// ---------------------------------------------------------------------------
// tb_rfile_sched
//
// Directed bench for rfile_sched at its default parameters (2-entry buffer,
// starvation limit 4). A small register-file array stands in for the real
// register file. Each stimulus step also pushes the response and drain
// values it should produce. A monitor then pops and compares them whenever
// the DUT presents rsp_valid or rf_rd_write.
// ---------------------------------------------------------------------------
module tb_rfile_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [4:0]  rd_rs1_addr = 5'd0;
  logic [4:0]  rd_rs2_addr = 5'd0;
  logic        rd_ack;
  logic        rsp_valid;
  logic [31:0] rsp_rs1;
  logic [31:0] rsp_rs2;
  logic        wr_req = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_ready;
  logic [31:0] rf_rs1_addr;
  logic [31:0] rf_rs2_addr;
  logic        rf_read_rs1;
  logic        rf_read_rs2;
  logic [31:0] rf_rd;
  logic [31:0] rf_rd_data;
  logic        rf_rd_write;
  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;

  logic [31:0] tb_rf [32];
  logic [63:0] exp_q[$];
  logic [36:0] exp_wr_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  rfile_sched dut (
    .clk         (clk),
    .reset       (reset),
    .rd_req      (rd_req),
    .rd_rs1_addr (rd_rs1_addr),
    .rd_rs2_addr (rd_rs2_addr),
    .rd_ack      (rd_ack),
    .rsp_valid   (rsp_valid),
    .rsp_rs1     (rsp_rs1),
    .rsp_rs2     (rsp_rs2),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_read_rs1 (rf_read_rs1),
    .rf_read_rs2 (rf_read_rs2),
    .rf_rd       (rf_rd),
    .rf_rd_data  (rf_rd_data),
    .rf_rd_write (rf_rd_write),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2)
  );

  // ---- clock / reset -----------------------------------------------------
  always #5 clk = ~clk;

  // ---- register-file model -----------------------------------------------
  assign rf_rs1 = tb_rf[rf_rs1_addr[4:0]];
  assign rf_rs2 = tb_rf[rf_rs2_addr[4:0]];

  always @(posedge clk) begin
    if (rf_rd_write) begin
      tb_rf[rf_rd[4:0]] <= rf_rd_data;
    end
  end

  // ---- check helper ------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- driver tasks ------------------------------------------------------
  // One cycle of stimulus. Inputs change on the falling edge. The
  // combinational grant outputs are checked 1 time unit later.
  task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                      input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic e_ack, input logic e_wr, input logic e_ready);
    @(negedge clk);
    rd_req      = r;
    rd_rs1_addr = a1;
    rd_rs2_addr = a2;
    wr_req      = w;
    wr_addr     = wa;
    wr_data     = wd;
    #1;
    chk("rd_ack", 64'(rd_ack), 64'(e_ack));
    chk("rf_rd_write", 64'(rf_rd_write), 64'(e_wr));
    chk("wr_ready", 64'(wr_ready), 64'(e_ready));
  endtask

  task automatic idle(input logic e_wr, input logic e_ready);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, e_wr, e_ready);
  endtask

  task automatic exp_rsp(input logic [31:0] v1, input logic [31:0] v2);
    exp_q.push_back({v1, v2});
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  // ---- scoreboard monitor ------------------------------------------------
  initial begin
    logic [63:0] e;
    logic [36:0] ew;
    forever begin
      @(negedge clk);
      #3;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_spurious", 64'(rsp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", {rsp_rs1, rsp_rs2}, e);
        end
      end
      if (rf_rd_write) begin
        chk("rw_exclusive", 64'(rf_read_rs1 | rf_read_rs2), 64'd0);
        chk("rf_rd_upper", 64'(rf_rd[31:5]), 64'd0);
        if (exp_wr_q.size() == 0) begin
          chk("rf_write_spurious", 64'(rf_rd_write), 64'd0);
        end else begin
          ew = exp_wr_q.pop_front();
          chk("rf_write", 64'({rf_rd[4:0], rf_rd_data}), 64'(ew));
        end
      end
    end
  end

  // ---- stimulus ----------------------------------------------------------
  initial begin
    for (int i = 0; i < 32; i++) begin
      tb_rf[i] = 32'd0;
    end
    tb_rf[4] = 32'h44;
    tb_rf[9] = 32'h99;

    // Reset state.
    #1 reset = 1'b0;
    #2;
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_rd_ack", 64'(rd_ack), 64'd0);
    chk("rst_rf_write", 64'(rf_rd_write), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp", {rsp_rs1, rsp_rs2}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Buffered write drains on the next idle cycle, then reads back.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    exp_wr(5'd5, 32'hDEADBEEF);
    idle(1'b1, 1'b1);
    step(1'b1, 5'd5, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    exp_rsp(32'hDEADBEEF, 32'h99);

    // Same-cycle write forwarding; rs2 = x0 reads zero.
    step(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 32'h11, 1'b1, 1'b0, 1'b1);
    exp_rsp(32'h11, 32'h0);
    exp_wr(5'd7, 32'h11);
    idle(1'b1, 1'b1);

    // Fill the buffer under continuous reads: forced drain, then the
    // youngest buffered value shadows the stale register-file value.
    step(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'hA, 1'b1, 1'b0, 1'b1);
    exp_rsp(32'hA, 32'hA);
    exp_wr(5'd3, 32'hA);
    step(1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 32'hB, 1'b1, 1'b0, 1'b1);
    exp_rsp(32'hB, 32'h44);
    exp_wr(5'd3, 32'hB);
    step(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    exp_rsp(32'hB, 32'hB);
    idle(1'b1, 1'b1);

    // Starvation: four reads overtake one waiting write, then a forced drain.
    step(1'b1, 5'd8, 5'd9, 1'b1, 5'd8, 32'h88, 1'b1, 1'b0, 1'b1);
    exp_rsp(32'h88, 32'h99);
    exp_wr(5'd8, 32'h88);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd8, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
      exp_rsp(32'h88, 32'h99);
    end
    step(1'b1, 5'd8, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 5'd8, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    exp_rsp(32'h88, 32'h99);

    // Writes to x0 are accepted and dropped.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd0, 5'd9, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
    exp_rsp(32'h0, 32'h99);
    idle(1'b0, 1'b1);

    // Reset with two entries buffered and a forced drain pending.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd10, 5'd11, 1'b1, 5'd11, 32'hB0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rd_req = 1'b1;
    wr_req = 1'b0;
    #1;
    chk("pre_rst_force", 64'(rf_rd_write), 64'd1);
    chk("pre_rst_ack", 64'(rd_ack), 64'd0);
    chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("pre_rst_rsp", {rsp_rs1, rsp_rs2}, {32'hA0, 32'hB0});
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_write", 64'(rf_rd_write), 64'd0);
    chk("rst_mid_read", 64'({rd_ack, rf_read_rs1, rf_read_rs2}), 64'd0);
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_rsp", {rsp_rs1, rsp_rs2}, 64'd0);
    chk("rst_mid_wr_ready", 64'(wr_ready), 64'd0);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    step(1'b1, 5'd10, 5'd11, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    exp_rsp(32'h0, 32'h0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);

    chk("rsp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rfile_sched.md
RFILE_SCHED -- requirements
Module: rfile_sched

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 2, giving the number of write-buffer entries (legal range 1..4).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, giving the maximum consecutive granted reads while the write buffer is non-empty.
REQ-003 Ports, in order:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous active-low reset.
- rd_req  in  1  read request.
- rd_rs1_addr  in  5  source register 1 index.
- rd_rs2_addr  in  5  source register 2 index.
- rd_ack  out  1  read granted this cycle.
- rsp_valid  out  1  read response valid.
- rsp_rs1  out  32  read response for source 1.
- rsp_rs2  out  32  read response for source 2.
- wr_req  in  1  write request.
- wr_addr  in  5  destination register index.
- wr_data  in  32  write data.
- wr_ready  out  1  write accepted when wr_req and wr_ready are both high.
- rf_rs1_addr  out  32  register-file read address 1; bits [31:5] are 0.
- rf_rs2_addr  out  32  register-file read address 2; bits [31:5] are 0.
- rf_read_rs1  out  1  register-file read strobe 1.
- rf_read_rs2  out  1  register-file read strobe 2.
- rf_rd  out  32  register-file write index; bits [31:5] are 0.
- rf_rd_data  out  32  register-file write data.
- rf_rd_write  out  1  register-file write strobe.
- rf_rs1  in  32  register-file read data 1, combinational.
- rf_rs2  in  32  register-file read data 2, combinational.

Function
REQ-004 SHALL never assert a read strobe (rf_read_rs1/rf_read_rs2) and rf_rd_write in the same cycle.
REQ-005 SHALL hold a FIFO write buffer of WBUF_DEPTH entries (5-bit address, 32-bit data), and wr_ready SHALL equal count < WBUF_DEPTH.
REQ-006 SHALL discard an accepted write to address 0 without enqueuing it; wr_ready still applies.
REQ-007 SHALL compute the per-cycle grant combinationally with this priority:
- FORCE_WR when the buffer is non-empty and (count == WBUF_DEPTH or starve_cnt == STARVE_LIMIT);
- otherwise READ when rd_req is high;
- otherwise WRITE when the buffer is non-empty;
- otherwise IDLE.
REQ-008 On READ, SHALL assert rd_ack and both read strobes, drive rf_rs*_addr from the request, and keep rf_rd_write low.
REQ-009 On WRITE or FORCE_WR, SHALL drive the head entry onto rf_rd/rf_rd_data, assert rf_rd_write, keep rd_ack low, and pop the head at the posedge.
REQ-010 On IDLE, SHALL hold all strobes and rd_ack low.
REQ-011 Read data per source SHALL be resolved with this precedence:
- address 0 gives 0;
- else a same-cycle accepted wr_req with a matching address gives wr_data;
- else the youngest matching buffer entry gives its data;
- else the rf_rs* value.
REQ-012 SHALL register the resolved data into rsp_rs1/rsp_rs2 and pulse rsp_valid for exactly one cycle, the cycle after READ (latency 1); rsp_* SHALL hold between grants.
REQ-013 starve_cnt SHALL:
- increment on READ while the buffer is non-empty (saturating at STARVE_LIMIT);
- clear on any write grant;
- clear on any cycle with an empty buffer.
REQ-014 Simultaneous push and pop SHALL keep count unchanged, and the pushed entry SHALL become the tail.
REQ-015 FIFO pointers SHALL wrap modulo WBUF_DEPTH.

Reset
REQ-016 While reset is low, the block SHALL asynchronously force:
- count = 0, pointers = 0, starve_cnt = 0;
- rsp_valid = 0, rsp_rs1 = 0, rsp_rs2 = 0;
- rd_ack, rf_read_rs1, rf_read_rs2 and rf_rd_write low;
- wr_ready low.
REQ-017 On reset assertion mid-operation, buffered writes SHALL be lost, and no partial rf write SHALL occur after reset asserts.
REQ-018 The first grant SHALL be evaluated in the first cycle after reset deasserts.

Verification
REQ-019 Write x5=0xDEADBEEF with no reads pending -> next cycle rf_rd_write=1, rf_rd=5, rf_rd_data=0xDEADBEEF; then read rs1=5 -> rsp_rs1=0xDEADBEEF one cycle after rd_ack.
REQ-020 wr x7=0x11 and rd_req rs1=7, rs2=0 in the same cycle -> READ granted, rsp_rs1=0x11 (forwarded), rsp_rs2=0; the write drains on the next non-read cycle.
REQ-021 Fill the buffer (2 writes) while rd_req is held high -> wr_ready=0, FORCE_WR drains the head, and rd_ack is low that cycle.
REQ-022 rd_req held continuously with 1 buffered write, STARVE_LIMIT=4 -> 4 READ grants, then 1 FORCE_WR, then READ resumes.
REQ-023 Write to x0 with data 0xFFFFFFFF -> no rf_rd_write ever; a read of rs1=0 returns 0.
REQ-024 Assert reset with 2 entries buffered -> strobes drop immediately, rsp_valid=0, wr_ready=1 after release, and no buffered write reaches the register file.
